// File: rtl/hdmi_tap_pkg.sv
// Shared constants and helpers for the HDMI channel tap.
// Optional build macro: HDMI_TAP_OVF_COUNT_EN adds a saturating dropped-word counter.
package hdmi_tap_pkg;

    localparam int unsigned SYM_W         = 10;
    localparam int unsigned SYMS_PER_WORD = 4;
    localparam int unsigned LOG_W         = SYM_W * SYMS_PER_WORD;
    localparam int unsigned SLOT_W        = 2;
    localparam int unsigned OVF_CNT_W     = 16;

    // Symbol-slot indices; slot 0 lands in the most significant field
    localparam logic [SLOT_W-1:0] SLOT_0 = 2'd0;
    localparam logic [SLOT_W-1:0] SLOT_1 = 2'd1;
    localparam logic [SLOT_W-1:0] SLOT_2 = 2'd2;
    localparam logic [SLOT_W-1:0] SLOT_3 = 2'd3;

    typedef logic [SYM_W-1:0]  sym_t;
    typedef logic [LOG_W-1:0]  log_word_t;
    typedef logic [SLOT_W-1:0] slot_t;

    // Return word with the given slot replaced by sym
    function automatic log_word_t put_sym(input log_word_t word, input slot_t slot, input sym_t sym);
        log_word_t res;
        res = word;
        case (slot)
            SLOT_0:  res[4*SYM_W-1:3*SYM_W] = sym;
            SLOT_1:  res[3*SYM_W-1:2*SYM_W] = sym;
            SLOT_2:  res[2*SYM_W-1:1*SYM_W] = sym;
            default: res[1*SYM_W-1:0]       = sym;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hdmi_log_fifo.sv
// Synchronous FIFO with registered (non show-ahead) read data.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module hdmi_log_fifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             push_drop_c,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             do_push, do_pop;

    // Pointer, count, flag and read-data next state
    always_comb begin
        do_pop      = pop & ~empty_q;
        do_push     = push & (~full_q | do_pop);
        push_drop_c = push & ~do_push;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            rdata_d  = mem[rd_ptr_q];
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        empty_d = (cnt_d == CW'(0));
        full_d  = (cnt_d == CW'(DEPTH));
    end

    // Control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage array, no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign rdata = rdata_q;

endmodule

// File: rtl/hdmi_channel_tap.sv
// One TMDS channel of the HDMI tap: 1-cycle symbol passthrough plus a 4-symbol log packer feeding a FIFO.
// Optional build macro: HDMI_TAP_OVF_COUNT_EN adds log_ovf_count (saturating dropped-word count).
module hdmi_channel_tap
    import hdmi_tap_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SYM_W-1:0] rx,
    output logic [SYM_W-1:0] tx,
    output logic             txclk,
    output logic             log_empty,
    input  logic             log_read,
    output logic [LOG_W-1:0] log_data,
    output logic             log_ovf
`ifdef HDMI_TAP_OVF_COUNT_EN
    ,
    output logic [OVF_CNT_W-1:0] log_ovf_count
`endif
);

    sym_t      tx_q, tx_d;
    slot_t     k_q, k_d;
    log_word_t word_q, word_d;
    logic      ovf_q, ovf_d;
    logic      push_c;
    logic      drop_c;
    logic      fifo_full;

    // Passthrough, packing counter and partial-word assembly
    always_comb begin
        tx_d   = rx;
        k_d    = k_q + SLOT_W'(1);
        word_d = put_sym(word_q, k_q, rx);
        push_c = (k_q == SLOT_3);
        ovf_d  = ovf_q | drop_c;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_q   <= '0;
            k_q    <= SLOT_0;
            word_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            k_q    <= k_d;
            word_q <= word_d;
            ovf_q  <= ovf_d;
        end
    end

    hdmi_log_fifo #(
        .WIDTH (LOG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_log_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push_c),
        .wdata       (word_d),
        .full        (fifo_full),
        .push_drop_c (drop_c),
        .pop         (log_read),
        .empty       (log_empty),
        .rdata       (log_data)
    );

`ifdef HDMI_TAP_OVF_COUNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    // Saturating dropped-word counter
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop_c && (ovf_cnt_q != {OVF_CNT_W{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign log_ovf_count = ovf_cnt_q;
`endif

    // Full flag is only consumed inside the FIFO's accept logic
    logic unused_full;
    assign unused_full = fifo_full;

    // Inverted clock centres tx data on the forwarded clock
    assign txclk   = ~clk;
    assign tx      = tx_q;
    assign log_ovf = ovf_q;

endmodule

// File: tb/tb_hdmi_channel_tap.sv
// Scoreboard bench for hdmi_channel_tap: a queue model of the log FIFO is fed as symbols are driven
// and drained as reads are issued; every cycle tx, flags and log_data are compared.
module tb_hdmi_channel_tap;
    import hdmi_tap_pkg::*;

    localparam int unsigned DEPTH = 512;

    logic             clk;
    logic             reset;
    logic [SYM_W-1:0] rx;
    logic [SYM_W-1:0] tx;
    logic             txclk;
    logic             log_empty;
    logic             log_read;
    logic [LOG_W-1:0] log_data;
    logic             log_ovf;
`ifdef HDMI_TAP_OVF_COUNT_EN
    logic [15:0]      log_ovf_count;
`endif

    hdmi_channel_tap #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .tx        (tx),
        .txclk     (txclk),
        .log_empty (log_empty),
        .log_read  (log_read),
        .log_data  (log_data),
        .log_ovf   (log_ovf)
`ifdef HDMI_TAP_OVF_COUNT_EN
        ,
        .log_ovf_count (log_ovf_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [LOG_W-1:0] m_q[$];
    logic [LOG_W-1:0] m_word;
    logic [LOG_W-1:0] m_data;
    int               m_k;
    logic             m_ovf;
    int               m_ovf_cnt;
    logic [SYM_W-1:0] sym_cnt;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Called just after a negedge: drive one symbol, update the model, check after the posedge.
    task automatic cycle(input logic [SYM_W-1:0] s, input logic rd);
        bit popd;
        rx       = s;
        log_read = rd;
        popd = rd && (m_q.size() != 0);
        if (popd) m_data = m_q.pop_front();
        case (m_k)
            0:       m_word[39:30] = s;
            1:       m_word[29:20] = s;
            2:       m_word[19:10] = s;
            default: m_word[9:0]   = s;
        endcase
        if (m_k == 3) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_word);
            else begin
                m_ovf = 1'b1;
                if (m_ovf_cnt < 16'hFFFF) m_ovf_cnt++;
            end
        end
        m_k = (m_k + 1) % 4;
        @(posedge clk);
        #1;
        check_val("tx", 64'(tx), 64'(s));
        check_val("txclk_hi_clk", 64'(txclk), 64'(0));
        check_val("log_empty", 64'(log_empty), 64'(m_q.size() == 0));
        check_val("log_data", 64'(log_data), 64'(m_data));
        check_val("log_ovf", 64'(log_ovf), 64'(m_ovf));
`ifdef HDMI_TAP_OVF_COUNT_EN
        check_val("log_ovf_count", 64'(log_ovf_count), 64'(m_ovf_cnt));
`endif
        @(negedge clk);
        #1;
        check_val("txclk_lo_clk", 64'(txclk), 64'(1));
    endtask

    // Assert reset asynchronously, check reset values, release at a negedge.
    task automatic do_reset();
        reset    = 1'b1;
        log_read = 1'b0;
        m_q.delete();
        m_word    = '0;
        m_data    = '0;
        m_k       = 0;
        m_ovf     = 1'b0;
        m_ovf_cnt = 0;
        #1;
        check_val("rst_log_empty_async", 64'(log_empty), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_tx", 64'(tx), 64'(0));
        check_val("rst_log_empty", 64'(log_empty), 64'(1));
        check_val("rst_log_data", 64'(log_data), 64'(0));
        check_val("rst_log_ovf", 64'(log_ovf), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        rx       = '0;
        log_read = 1'b0;
        sym_cnt  = '0;
        do_reset();

        // 1: passthrough of alternating patterns
        cycle(10'h155, 1'b0);
        cycle(10'h2AA, 1'b0);
        cycle(10'h155, 1'b0);
        cycle(10'h2AA, 1'b0);
        cycle(10'h3FF, 1'b0);

        // 2 and 4: known word, pop it, then reads while empty are ignored
        do_reset();
        cycle(10'h3FF, 1'b0);
        cycle(10'h000, 1'b0);
        cycle(10'h155, 1'b0);
        cycle(10'h2AA, 1'b0);
        check_val("known_word_not_empty", 64'(log_empty), 64'(0));
        cycle(10'h001, 1'b1);
        check_val("known_word", 64'(log_data), 64'h00FFC00556AA);
        cycle(10'h002, 1'b1);
        cycle(10'h003, 1'b1);
        check_val("empty_read_hold", 64'(log_data), 64'h00FFC00556AA);
        check_val("empty_read_empty", 64'(log_empty), 64'(1));

        // 3: overflow with reads idle, then drain the full FIFO in order
        do_reset();
        for (int i = 0; i < 4 * DEPTH + 4; i++) begin
            cycle(sym_cnt, 1'b0);
            sym_cnt++;
        end
        check_val("ovf_set", 64'(log_ovf), 64'(1));
        for (int i = 0; i < DEPTH; i++) begin
            cycle(sym_cnt, 1'b1);
            sym_cnt++;
        end
        check_val("ovf_sticky", 64'(log_ovf), 64'(1));

        // 5: sustained reading at one word per four cycles
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            cycle(sym_cnt, (i % 4) == 3);
            sym_cnt++;
        end
        check_val("no_ovf_streaming", 64'(log_ovf), 64'(0));

        // 6: reset two symbols into a word with data pending in the FIFO
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(sym_cnt, 1'b0);
            sym_cnt++;
        end
        check_val("pre_reset_not_empty", 64'(log_empty), 64'(0));
        do_reset();
        cycle(10'h011, 1'b0);
        cycle(10'h022, 1'b0);
        cycle(10'h033, 1'b0);
        cycle(10'h044, 1'b0);
        cycle(10'h055, 1'b1);
        check_val("post_reset_word", 64'(log_data), 64'({10'h011, 10'h022, 10'h033, 10'h044}));
        cycle(10'h066, 1'b0);
        check_val("post_reset_empty", 64'(log_empty), 64'(1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
